// File: rtl/score_ctrl_pkg.sv
// Shared constants for the score/game-state stage: state encodings, BCD
// digit width, default game tuning and a single-digit BCD adder helper.
package score_ctrl_pkg;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int DEF_KILL_POINTS   = 1;
  localparam int DEF_LIVES_INIT    = 3;
  localparam int DEF_INVULN_FRAMES = 120;

  // Adds two BCD digits; operands may be 0..9. Returns {carry, digit}.
  function automatic logic [BCD_DIGIT_W:0] bcd_digit_add(
    input logic [BCD_DIGIT_W-1:0] a,
    input logic [BCD_DIGIT_W-1:0] b
  );
    logic [BCD_DIGIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > 5'd9) begin
      return {1'b1, 4'(s - 5'd10)};
    end
    return {1'b0, s[BCD_DIGIT_W-1:0]};
  endfunction

endpackage

// File: rtl/score_ctrl_bcd_add_sat.sv
// Adds one BCD digit (0..9) to an N-digit BCD value. Instead of wrapping
// past the top digit the result sticks at all nines.
module score_ctrl_bcd_add_sat
  import score_ctrl_pkg::*;
#(
  parameter int SCORE_DIGITS = 4
) (
  input  logic [BCD_DIGIT_W*SCORE_DIGITS-1:0] value_bcd,
  input  logic [BCD_DIGIT_W-1:0]              addend,
  output logic [BCD_DIGIT_W*SCORE_DIGITS-1:0] sum_bcd
);

  logic [BCD_DIGIT_W*SCORE_DIGITS-1:0] sum_raw;
  logic [BCD_DIGIT_W-1:0]              carry;
  logic [BCD_DIGIT_W:0]                dsum;

  // Ripple the addend through the digits; after digit 0 the carry is 0/1.
  always_comb begin
    carry   = addend;
    dsum    = '0;
    sum_raw = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      dsum = bcd_digit_add(value_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W], carry);
      sum_raw[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dsum[BCD_DIGIT_W-1:0];
      carry = {3'b000, dsum[BCD_DIGIT_W]};
    end
  end

  assign sum_bcd = (carry != '0) ? {SCORE_DIGITS{4'h9}} : sum_raw;

endmodule

// File: rtl/score_ctrl.sv
// Game-state and scoring stage. Folds per-pixel crash levels into at most
// one kill and one hit event per video frame, and keeps score, lives,
// post-hit invulnerability and the IDLE/PLAY/OVER state.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | after reset, waiting for a start edge; crashes ignored
//   ST_PLAY | game running; crashes gathered per frame, applied at frame end
//   ST_OVER | lives exhausted; score/lives frozen until a start edge
module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int SCORE_DIGITS     = 4,
  parameter int KILL_POINTS      = DEF_KILL_POINTS,
  parameter int LIVES_INIT       = DEF_LIVES_INIT,
  parameter int INVULN_FRAMES    = DEF_INVULN_FRAMES,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                v_sync_i,
  input  logic                                crash_enemy_bullet_i,
  input  logic                                crash_me_enemy_i,
  input  logic                                start_i,
  output logic [BCD_DIGIT_W*SCORE_DIGITS-1:0] score_bcd_o,
  output logic [2:0]                          lives_o,
  output logic                                playing_o,
  output logic                                game_over_o,
  output logic                                invuln_o,
  output logic                                frame_end_o
);

  localparam int          SCORE_W    = BCD_DIGIT_W * SCORE_DIGITS;
  localparam logic        VS_ACTIVE  = (VSYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [2:0]  LIVES_LOAD = 3'(LIVES_INIT);
  localparam logic [7:0]  INV_LOAD   = 8'(INVULN_FRAMES);

  logic [1:0]         state_q, state_nxt;
  logic [7:0]         invuln_cnt_q, invuln_nxt;
  logic               kill_seen_q, kill_nxt;
  logic               hit_seen_q, hit_nxt;
  logic               vs_prev_q;
  logic               start_prev_q;
  logic [SCORE_W-1:0] score_nxt, score_inc;
  logic [2:0]         lives_nxt;
  logic               frame_end, start_rise, kill_evt, hit_evt;

  score_ctrl_bcd_add_sat #(
    .SCORE_DIGITS(SCORE_DIGITS)
  ) u_bcd_add_sat (
    .value_bcd(score_bcd_o),
    .addend   (4'(KILL_POINTS)),
    .sum_bcd  (score_inc)
  );

  // Frame/start edge detection and next-state game rules.
  always_comb begin
    frame_end  = (vs_prev_q != VS_ACTIVE) && (v_sync_i == VS_ACTIVE);
    start_rise = start_i && !start_prev_q;
    // A crash on the frame-end cycle itself still belongs to the ending frame.
    kill_evt   = kill_seen_q | crash_enemy_bullet_i;
    hit_evt    = hit_seen_q | crash_me_enemy_i;

    state_nxt  = state_q;
    score_nxt  = score_bcd_o;
    lives_nxt  = lives_o;
    invuln_nxt = invuln_cnt_q;
    kill_nxt   = kill_seen_q;
    hit_nxt    = hit_seen_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        kill_nxt   = 1'b0;
        hit_nxt    = 1'b0;
        invuln_nxt = '0;
        if (start_rise) begin
          state_nxt = ST_PLAY;
          score_nxt = '0;
          lives_nxt = LIVES_LOAD;
        end
      end
      ST_PLAY: begin
        if (frame_end) begin
          kill_nxt = 1'b0;
          hit_nxt  = 1'b0;
          if (kill_evt) begin
            score_nxt = score_inc;
          end
          if (hit_evt && (invuln_cnt_q == '0)) begin
            if (lives_o == 3'd1) begin
              lives_nxt = 3'd0;
              state_nxt = ST_OVER;
            end else begin
              lives_nxt  = lives_o - 3'd1;
              invuln_nxt = INV_LOAD;
            end
          end else if (invuln_cnt_q != '0) begin
            invuln_nxt = invuln_cnt_q - 8'd1;
          end
        end else begin
          kill_nxt = kill_evt;
          hit_nxt  = hit_evt;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register game state and all outputs; reset forces the idle picture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      score_bcd_o  <= '0;
      lives_o      <= LIVES_LOAD;
      invuln_cnt_q <= '0;
      kill_seen_q  <= 1'b0;
      hit_seen_q   <= 1'b0;
      vs_prev_q    <= ~VS_ACTIVE;
      start_prev_q <= 1'b0;
      playing_o    <= 1'b0;
      game_over_o  <= 1'b0;
      invuln_o     <= 1'b0;
      frame_end_o  <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      score_bcd_o  <= score_nxt;
      lives_o      <= lives_nxt;
      invuln_cnt_q <= invuln_nxt;
      kill_seen_q  <= kill_nxt;
      hit_seen_q   <= hit_nxt;
      vs_prev_q    <= v_sync_i;
      start_prev_q <= start_i;
      playing_o    <= (state_nxt == ST_PLAY);
      game_over_o  <= (state_nxt == ST_OVER);
      invuln_o     <= (invuln_nxt != '0);
      frame_end_o  <= frame_end;
    end
  end

endmodule

// File: tb/tb_score_ctrl.sv
// Randomised bench for score_ctrl against an integer-level game model.
module tb_score_ctrl;

  localparam int SD        = 3;
  localparam int KP        = 9;
  localparam int LI        = 3;
  localparam int IFR       = 4;
  localparam int MAX_SCORE = 999;

  logic            clk = 1'b0;
  logic            rst, v_sync_i, crash_enemy_bullet_i, crash_me_enemy_i, start_i;
  logic [4*SD-1:0] score_bcd_o;
  logic [2:0]      lives_o;
  logic            playing_o, game_over_o, invuln_o, frame_end_o;

  always #5 clk = ~clk;

  score_ctrl #(
    .SCORE_DIGITS    (SD),
    .KILL_POINTS     (KP),
    .LIVES_INIT      (LI),
    .INVULN_FRAMES   (IFR),
    .VSYNC_ACTIVE_LOW(1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .v_sync_i            (v_sync_i),
    .crash_enemy_bullet_i(crash_enemy_bullet_i),
    .crash_me_enemy_i    (crash_me_enemy_i),
    .start_i             (start_i),
    .score_bcd_o         (score_bcd_o),
    .lives_o             (lives_o),
    .playing_o           (playing_o),
    .game_over_o         (game_over_o),
    .invuln_o            (invuln_o),
    .frame_end_o         (frame_end_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 play, 2 over; score and counters as integers.
  int m_mode, m_score, m_lives, m_inv;
  bit m_kill, m_hit, m_vs_prev, m_start_prev, m_fe;
  bit start_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit r, input bit vs, input bit k, input bit h, input bit st);
    bit fe;
    if (r) begin
      m_mode = 0; m_score = 0; m_lives = LI; m_inv = 0;
      m_kill = 0; m_hit = 0; m_vs_prev = 1; m_start_prev = 0; m_fe = 0;
      return;
    end
    fe = m_vs_prev && !vs;
    if (m_mode != 1) begin
      m_kill = 0; m_hit = 0; m_inv = 0;
      if (st && !m_start_prev) begin
        m_mode = 1; m_score = 0; m_lives = LI;
      end
    end else if (fe) begin
      if (m_kill || k) m_score = (m_score + KP > MAX_SCORE) ? MAX_SCORE : m_score + KP;
      if ((m_hit || h) && m_inv == 0) begin
        if (m_lives == 1) begin
          m_lives = 0; m_mode = 2;
        end else begin
          m_lives = m_lives - 1; m_inv = IFR;
        end
      end else if (m_inv > 0) begin
        m_inv = m_inv - 1;
      end
      m_kill = 0; m_hit = 0;
    end else begin
      m_kill = m_kill | k;
      m_hit  = m_hit | h;
    end
    m_fe = fe;
    m_vs_prev = vs;
    m_start_prev = st;
  endtask

  task automatic tick(input bit r, input bit vs, input bit k, input bit h, input bit st);
    rst = r; v_sync_i = vs; crash_enemy_bullet_i = k; crash_me_enemy_i = h; start_i = st;
    @(posedge clk);
    model_step(r, vs, k, h, st);
    #1;
    chk("score",     32'(score_bcd_o), to_bcd(m_score));
    chk("lives",     32'(lives_o),     32'(m_lives));
    chk("playing",   32'(playing_o),   32'(m_mode == 1));
    chk("game_over", 32'(game_over_o), 32'(m_mode == 2));
    chk("invuln",    32'(invuln_o),    32'(m_inv != 0));
    chk("frame_end", 32'(frame_end_o), 32'(m_fe));
  endtask

  // One frame: v_sync high, then low for the last two cycles.
  task automatic run_frame(input int len, input int pk, input int ph, input int ps, input int pr);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(99) < ps) start_lvl = ~start_lvl;
      tick($urandom_range(999) < pr, i < len - 2,
           $urandom_range(99) < pk, $urandom_range(99) < ph, start_lvl);
    end
  endtask

  initial begin
    rst = 1; v_sync_i = 1; crash_enemy_bullet_i = 0; crash_me_enemy_i = 0; start_i = 0;
    start_lvl = 0;
    model_step(1, 1, 0, 0, 0);

    repeat (3) tick(1, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    // Held start enters PLAY exactly once.
    repeat (3) tick(0, 1, 0, 0, 1);
    tick(0, 1, 0, 0, 0);
    chk("start_once_play", 32'(playing_o), 32'd1);
    chk("start_lives", 32'(lives_o), 32'd3);

    // 40 kill pixels inside one frame bank one frame's worth of points.
    for (int i = 0; i < 44; i++) tick(0, i < 42, (i >= 1) && (i < 41), 0, 0);
    chk("kill_once", 32'(score_bcd_o), 32'h009);

    // Kill every frame: carries through 018, 108 and saturation at 999.
    repeat (130) run_frame(10, 80, 0, 0, 0);
    chk("score_sat", 32'(score_bcd_o), 32'h999);

    // Hits with invulnerability until the game ends; then crashes in OVER.
    repeat (40) run_frame(10, 30, 40, 0, 0);
    repeat (5) run_frame(10, 60, 60, 0, 0);

    // Restart from OVER (or PLAY, where the edge is ignored).
    repeat (2) tick(0, 1, 0, 0, 1);
    tick(0, 1, 0, 0, 0);
    start_lvl = 0;

    // Kill only on the frame-end cycle with the sticky flag clear.
    repeat (2) run_frame(10, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, i < 8, i == 8, 0, 0);

    // A few kills, a hit to arm invulnerability, then a one-cycle reset.
    repeat (4) run_frame(10, 50, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, i < 8, 0, i == 4, 0);
    tick(1, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("rst_mid_play", 32'(playing_o), 32'd0);

    // Random soak with start toggles and sporadic resets.
    repeat (300) run_frame($urandom_range(16, 6), $urandom_range(40), $urandom_range(25), 10, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
